// File: rtl/serial_sub_if.sv
// Handshake and result bundle for the bit-serial subtractor.
interface serial_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, borrow
   );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, WIDTH SHIFT cycles per result.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// SHIFT | one operand bit per edge through the subtractor cell
// DONE  | result valid, done pulses for this single cycle
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   serial_sub_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH-1:0]   res;
   logic [WIDTH-1:0]   diff_q;
   logic [CNT_W-1:0]   cnt;
   logic               br;
   logic               borrow_q;
   logic               busy_q;
   logic               done_q;
   logic               d;
   logic               bo;
   logic [WIDTH-1:0]   res_next;

   assign d        = opa[0] ^ opb[0] ^ br;
   assign bo       = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & br);
   assign res_next = {d, res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         opa      <= '0;
         opb      <= '0;
         res      <= '0;
         diff_q   <= '0;
         cnt      <= '0;
         br       <= 1'b0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  opa    <= bus.a;
                  opb    <= bus.b;
                  br     <= bus.bin;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               res <= res_next;
               opa <= opa >> 1;
               opb <= opb >> 1;
               br  <= bo;
               cnt <= cnt + 1'b1;
               // Last bit: publish the result in the same edge it is formed
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  diff_q   <= res_next;
                  borrow_q <= bo;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: 8-bit directed scenarios plus an exhaustive 4-bit back-to-back sweep.
module tb_serial_sub_ctrl;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   serial_sub_if #(.WIDTH(8)) if8 ();
   serial_sub_if #(.WIDTH(4)) if4 ();

   serial_sub_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_sub_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Returns {borrow, diff}: the true integer a - b - bin wrapped to w bits, borrow when negative.
   function automatic logic [32:0] ref_sub(input int w, input longint a, input longint b, input longint bin);
      longint r;
      longint m;
      logic [32:0] o;
      r = a - b - bin;
      m = (longint'(1) << w) - 1;
      o = '0;
      o[31:0] = 32'(r & m);
      o[32] = (r < 0);
      return o;
   endfunction

   // Timeline model: t counts cycles since acceptance; 0 means idle.
   int t8, t4;
   logic [32:0] pend8, pend4;
   logic [31:0] md8, md4;
   logic mb8, mb4;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t8 = 0; md8 = 0; mb8 = 0;
         t4 = 0; md4 = 0; mb4 = 0;
      end else begin
         if (t8 > 0) begin
            t8 = (t8 == 9) ? 0 : t8 + 1;
            if (t8 == 9) begin md8 = pend8[31:0]; mb8 = pend8[32]; end
         end else if (if8.start) begin
            t8 = 1;
            pend8 = ref_sub(8, longint'(if8.a), longint'(if8.b), longint'(if8.bin));
         end
         if (t4 > 0) begin
            t4 = (t4 == 5) ? 0 : t4 + 1;
            if (t4 == 5) begin md4 = pend4[31:0]; mb4 = pend4[32]; end
         end else if (if4.start) begin
            t4 = 1;
            pend4 = ref_sub(4, longint'(if4.a), longint'(if4.b), longint'(if4.bin));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("busy8",   longint'(if8.busy),   longint'(t8 > 0));
         check("done8",   longint'(if8.done),   longint'(t8 == 9));
         check("diff8",   longint'(if8.diff),   longint'(md8));
         check("borrow8", longint'(if8.borrow), longint'(mb8));
         check("busy4",   longint'(if4.busy),   longint'(t4 > 0));
         check("done4",   longint'(if4.done),   longint'(t4 == 5));
         check("diff4",   longint'(if4.diff),   longint'(md4));
         check("borrow4", longint'(if4.borrow), longint'(mb4));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output int lat, output int bcyc);
      if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1;
      tick();
      if8.start = 1'b0;
      if8.a = ~a; if8.b = ~b; if8.bin = ~bin;
      bcyc = if8.busy ? 1 : 0;
      lat = -1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (if8.busy) bcyc++;
         if (if8.done && lat < 0) lat = k;
      end
   endtask

   initial begin
      int lat, bcyc, pulses;
      logic [8:0] v;
      logic [32:0] e;
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0;
      if8.start = 0; if8.a = 0; if8.b = 0; if8.bin = 0;
      if4.start = 0; if4.a = 0; if4.b = 0; if4.bin = 0;
      tick(); tick();
      check("rst_busy", longint'(if8.busy), 0);
      check("rst_done", longint'(if8.done), 0);
      check("rst_diff", longint'(if8.diff), 0);
      rst_n = 1'b1;

      do_op8(8'd200, 8'd55, 1'b0, lat, bcyc);
      check("s1_latency", lat, 8);
      check("s1_busy_cycles", bcyc, 9);
      check("s1_diff", longint'(if8.diff), 145);
      check("s1_borrow", longint'(if8.borrow), 0);

      do_op8(8'd5, 8'd10, 1'b0, lat, bcyc);
      check("s2_diff", longint'(if8.diff), 251);
      check("s2_borrow", longint'(if8.borrow), 1);

      do_op8(8'd0, 8'd0, 1'b1, lat, bcyc);
      check("s3a_diff", longint'(if8.diff), 255);
      check("s3a_borrow", longint'(if8.borrow), 1);
      do_op8(8'd255, 8'd255, 1'b0, lat, bcyc);
      check("s3b_diff", longint'(if8.diff), 0);
      check("s3b_borrow", longint'(if8.borrow), 0);

      // Starts while busy (SHIFT at +3, DONE at +9) must be dropped
      if8.a = 8'd77; if8.b = 8'd33; if8.bin = 1'b1; if8.start = 1'b1;
      tick();
      pulses = 0;
      for (int k = 1; k <= 14; k++) begin
         if8.start = (k == 3 || k == 9);
         if8.a = 8'd11; if8.b = 8'd99; if8.bin = 1'b0;
         tick();
         if (if8.done) pulses++;
      end
      if8.start = 1'b0;
      check("s4_pulses", pulses, 1);
      check("s4_diff", longint'(if8.diff), 43);
      check("s4_borrow", longint'(if8.borrow), 0);
      check("s4_idle", longint'(if8.busy), 0);

      // Reset in the middle of SHIFT
      if8.a = 8'd150; if8.b = 8'd20; if8.bin = 1'b0; if8.start = 1'b1;
      tick();
      if8.start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check("s5_busy", longint'(if8.busy), 0);
      check("s5_done", longint'(if8.done), 0);
      check("s5_diff", longint'(if8.diff), 0);
      check("s5_borrow", longint'(if8.borrow), 0);
      tick(); tick();
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (if8.done) pulses++;
      end
      check("s5_no_done", pulses, 0);
      do_op8(8'd100, 8'd1, 1'b0, lat, bcyc);
      check("s5_diff_after", longint'(if8.diff), 99);
      check("s5_latency_after", lat, 8);

      // Exhaustive 4-bit sweep at the minimum issue interval of 6 cycles
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         if4.a = v[7:4]; if4.b = v[3:0]; if4.bin = v[8]; if4.start = 1'b1;
         e = ref_sub(4, longint'(v[7:4]), longint'(v[3:0]), longint'(v[8]));
         tick();
         if4.start = 1'b0;
         if4.a = ~v[7:4]; if4.b = ~v[3:0];
         tick(); tick(); tick(); tick();
         check("w4_done", longint'(if4.done), 1);
         check("w4_diff", longint'(if4.diff), longint'(e[3:0]));
         check("w4_borrow", longint'(if4.borrow), longint'(e[32]));
         tick();
      end
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepting edge.
REQ-007 bin  input  1  initial borrow-in; sampled on the accepting edge.
REQ-008 busy  output  1  high in SHIFT and DONE states.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 diff  output  WIDTH  registered result a - b - bin, modulo 2^WIDTH.
REQ-011 borrow  output  1  registered final borrow-out of the MSB stage.

Function
REQ-012 The block SHALL compute the result bit-serially, LSB first, through one full-subtractor cell:
- d = a_i ^ b_i ^ br
- bo = (~a_i & b_i) | (~(a_i ^ b_i) & br)
- br is the internal borrow flip-flop.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE, with the following transitions:
- IDLE -> SHIFT when start=1.
- SHIFT -> DONE after exactly WIDTH bit steps.
- DONE -> IDLE unconditionally.
REQ-014 Accepting edge (IDLE with start=1) SHALL perform all of the following:
- load a and b into operand shift registers;
- load br with bin;
- clear the bit counter;
- enter SHIFT.
REQ-015 Each SHIFT edge SHALL perform all of the following:
- process operand bit 0;
- shift d into the result shift register at the MSB;
- shift both operands right by one;
- set br to bo;
- increment the counter.
REQ-016 On the SHIFT edge processing bit WIDTH-1, diff SHALL load the full result and borrow SHALL load bo in the same edge, and the state SHALL go to DONE.
REQ-017 done SHALL be 1 only in DONE, i.e. for exactly one cycle, beginning WIDTH edges after the accepting edge.
REQ-018 diff and borrow SHALL hold their values until the next completing edge; a new start SHALL NOT disturb them until that operation's completing edge.
REQ-019 start while busy=1, including in DONE, SHALL be ignored with no queuing.
REQ-020 Back-to-back start is supported:
- start high in the cycle after DONE SHALL be accepted from IDLE.
- Minimum issue interval SHALL be WIDTH+2 cycles.
REQ-021 Changes on a, b or bin after the accepting edge SHALL NOT affect the in-flight result.
REQ-022 Counter width SHALL be ceil(log2(WIDTH))+1 bits; wrap-around SHALL NOT occur.

Reset
REQ-023 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, enter IDLE and clear all of the following to 0: busy, done, diff, borrow, br, counter, operand and result shift registers.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation; done SHALL NOT pulse for it, and diff SHALL read 0.
REQ-025 The first start SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Verification
REQ-026 The bench SHALL cover these directed scenarios (WIDTH=8):
- a=200, b=55, bin=0, start pulse -> done pulses 8 edges after accept; diff=145, borrow=0; busy high for 9 cycles.
- a=5, b=10, bin=0 -> diff=251, borrow=1.
- a=0, b=0, bin=1 -> diff=255, borrow=1; then a=255, b=255, bin=0 -> diff=0, borrow=0.
- start re-pulsed at cycles 3 and 9 after accept, with different a and b -> ignored; first result unchanged; exactly one done pulse.
- rst_n low at SHIFT cycle 4 -> busy, done, diff and borrow read 0 immediately; no done pulse; a subsequent start of 100-1 returns diff=99.
- Exhaustive 4-bit build (WIDTH=4): all 512 (a, b, bin) combinations, issued back-to-back; each diff/borrow SHALL match a - b - bin mod 16 and the borrow flag.
